// File: rtl/cammmp_tech_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cammmp_tech_pkg                                            |
// | Description : Shared opcodes, response bytes, UART FSM state types and   |
// |               the bit-period helper for the CAC block.                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package cammmp_tech_pkg;

  // Command opcodes carried in byte[7:4]
  localparam logic [3:0] OP_SELECT   = 4'h0;
  localparam logic [3:0] OP_WRITE_LO = 4'h1;
  localparam logic [3:0] OP_WRITE_HI = 4'h2;
  localparam logic [3:0] OP_READ     = 4'h3;

  // Fixed response bytes
  localparam logic [7:0] ACK_BYTE = 8'hAA;
  localparam logic [7:0] NAK_BYTE = 8'hEE;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // Clock cycles per UART bit (integer division)
  function automatic int bit_cycles(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cac_uart_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cac_uart_core                                              |
// | Description : 8N1 MSB-first UART: rx synchronizer + receiver FSM,        |
// |               transmitter FSM with a one-entry pending response slot.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cac_uart_core
  import cammmp_tech_pkg::*;
#(
  parameter int BIT_CYCLES = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  input  logic       tx_req,
  input  logic [7:0] tx_byte,
  output logic       tx_busy
);

  localparam int CNT_W = $clog2(BIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);

  logic             rx_meta, rx_sync, rx_prev;
  rx_state_t        rx_state, rx_next;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shift;
  logic             rx_tick, rx_half;

  tx_state_t        tx_state, tx_next;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shift;
  logic             tx_line;
  logic             tx_tick;
  logic             pend_valid;
  logic [7:0]       pend_byte;
  logic             take_pend, direct;

  assign rx_tick   = (rx_cnt == BIT_LAST);
  assign rx_half   = (rx_cnt == HALF_LAST);
  assign rx_byte   = rx_shift;
  assign tx_tick   = (tx_cnt == BIT_LAST);
  assign take_pend = (tx_state == TX_IDLE) && pend_valid;
  assign direct    = (tx_state == TX_IDLE) && !pend_valid && tx_req;
  // Busy means neither the shifter nor the pending slot can take a byte
  assign tx_busy   = pend_valid && (tx_state != TX_IDLE);
  assign uart_tx   = tx_line;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receiver state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_next;
  end

  // Receiver next state: mid-start recheck, 8 data samples, stop sample
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
      RX_START: if (rx_half) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && (rx_bit == 3'd7)) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Receiver bit timer, shifter and byte-valid strobe (framing errors dropped)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt   <= '0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= (rx_state == RX_STOP) && rx_tick && rx_sync;
      if ((rx_state == RX_IDLE) || (rx_next != rx_state) || rx_tick) rx_cnt <= '0;
      else                                                           rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == RX_START) begin
        rx_bit <= 3'd0;
      end else if ((rx_state == RX_DATA) && rx_tick) begin
        rx_bit   <= rx_bit + 3'd1;
        rx_shift <= {rx_shift[6:0], rx_sync};
      end
    end
  end

  // Transmitter state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_next;
  end

  // Transmitter next state: leave idle whenever a byte is available
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (pend_valid || tx_req) tx_next = TX_START;
      TX_START: if (tx_tick) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick && (tx_bit == 3'd7)) tx_next = TX_STOP;
      TX_STOP:  if (tx_tick) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // Transmitter line driver, shifter and pending slot; line resets high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt     <= '0;
      tx_bit     <= 3'd0;
      tx_shift   <= 8'h00;
      tx_line    <= 1'b1;
      pend_valid <= 1'b0;
      pend_byte  <= 8'h00;
    end else begin
      if ((tx_state == TX_IDLE) || tx_tick) tx_cnt <= '0;
      else                                  tx_cnt <= tx_cnt + 1'b1;
      case (tx_state)
        TX_IDLE: begin
          if (take_pend) begin
            tx_shift <= pend_byte;
            tx_line  <= 1'b0;
          end else if (direct) begin
            tx_shift <= tx_byte;
            tx_line  <= 1'b0;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            tx_line  <= tx_shift[7];
            tx_shift <= {tx_shift[6:0], 1'b1};
            tx_bit   <= 3'd0;
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            tx_bit <= tx_bit + 3'd1;
            if (tx_bit == 3'd7) begin
              tx_line <= 1'b1;
            end else begin
              tx_line  <= tx_shift[7];
              tx_shift <= {tx_shift[6:0], 1'b1};
            end
          end
        end
        default: ;
      endcase
      if (tx_req && !direct && (!pend_valid || take_pend)) begin
        pend_valid <= 1'b1;
        pend_byte  <= tx_byte;
      end else if (take_pend) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cammmp_tech.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cammmp_tech                                                |
// | Description : CAC top: UART byte commands against a 16 x 8-bit control   |
// |               register file, READ/NAK responses on the tx line.          |
// | Options     : CAC_ACK_EN - acknowledge SELECT/WRITE commands with 0xAA   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cammmp_tech
  import cammmp_tech_pkg::*;
#(
  parameter int MASTER_CLOCK_FREQUENCY = 100_000_000,
  parameter int CAC_UART_BAUDRATE      = 115200
) (
  input  logic clk_ref,
  input  logic rst,
  input  logic cac_uart_rx,
  output logic cac_uart_tx
);

  localparam int BIT_CYCLES = bit_cycles(MASTER_CLOCK_FREQUENCY, CAC_UART_BAUDRATE);

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       tx_req;
  logic [7:0] tx_byte;
  logic       tx_busy;
  logic [3:0] op;
  logic [3:0] arg;
  logic       resp_en;
  logic [3:0] sel;
  logic [7:0] regs [16];

  assign op  = rx_byte[7:4];
  assign arg = rx_byte[3:0];

  cac_uart_core #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_uart (
    .clk      (clk_ref),
    .rst_n    (rst),
    .uart_rx  (cac_uart_rx),
    .uart_tx  (cac_uart_tx),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .tx_req   (tx_req),
    .tx_byte  (tx_byte),
    .tx_busy  (tx_busy)
  );

  // Response selection; READ reads before any write of the same cycle
  always_comb begin
    resp_en = 1'b0;
    tx_byte = NAK_BYTE;
    case (op)
      OP_SELECT, OP_WRITE_LO, OP_WRITE_HI: begin
`ifdef CAC_ACK_EN
        resp_en = 1'b1;
        tx_byte = ACK_BYTE;
`endif
      end
      OP_READ: begin
        resp_en = 1'b1;
        tx_byte = regs[arg];
      end
      default: begin
        resp_en = 1'b1;
        tx_byte = NAK_BYTE;
      end
    endcase
  end

  // A response that finds both the shifter and the pending slot full is dropped
  assign tx_req = rx_valid && resp_en && !tx_busy;

  // Command execution against the pointer and register file
  always_ff @(posedge clk_ref or negedge rst) begin
    if (!rst) begin
      sel <= 4'h0;
      for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
    end else if (rx_valid) begin
      case (op)
        OP_SELECT:   sel <= arg;
        OP_WRITE_LO: regs[sel][3:0] <= arg;
        OP_WRITE_HI: regs[sel][7:4] <= arg;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cammmp_tech.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cammmp_tech                                             |
// | Description : Directed self-checking bench for cammmp_tech with a        |
// |               response scoreboard fed by a command model.                |
// | Options     : CAC_ACK_EN - expects 0xAA for SELECT/WRITE commands        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cammmp_tech;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 100_000;
  localparam int BITC   = CLK_HZ / BAUD;
`ifdef CAC_ACK_EN
  localparam bit ACK_EXP = 1'b1;
`else
  localparam bit ACK_EXP = 1'b0;
`endif

  logic clk;
  logic rst;
  logic rx;
  logic cac_uart_tx;

  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [7:0] exp_q [$];
  logic [7:0] m_regs [16];
  logic [3:0] m_sel;
  logic       mon_busy = 1'b0;
  time        mon_start_t = 0;
  time        stop_t = 0;

  cammmp_tech #(
    .MASTER_CLOCK_FREQUENCY (CLK_HZ),
    .CAC_UART_BAUDRATE      (BAUD)
  ) dut (
    .clk_ref     (clk),
    .rst         (rst),
    .cac_uart_rx (rx),
    .cac_uart_tx (cac_uart_tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_sel = 4'h0;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
  endtask

  // Drives one frame starting at a negedge; ends on a negedge
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 7; i >= 0; i--) begin
      rx = b[i];
      repeat (BITC) @(negedge clk);
    end
    stop_t = $time;
    rx = stop_bit;
    repeat (BITC) @(negedge clk);
    rx = 1'b1;
  endtask

  // Model the command, push the expected response, then send it
  task automatic send_cmd(input logic [7:0] b);
    case (b[7:4])
      4'h0: begin
        m_sel = b[3:0];
        if (ACK_EXP) exp_q.push_back(8'hAA);
      end
      4'h1: begin
        m_regs[m_sel] = {m_regs[m_sel][7:4], b[3:0]};
        if (ACK_EXP) exp_q.push_back(8'hAA);
      end
      4'h2: begin
        m_regs[m_sel] = {b[3:0], m_regs[m_sel][3:0]};
        if (ACK_EXP) exp_q.push_back(8'hAA);
      end
      4'h3:    exp_q.push_back(m_regs[b[3:0]]);
      default: exp_q.push_back(8'hEE);
    endcase
    send_byte(b, 1'b1);
  endtask

  task automatic gap(input int bits);
    repeat (bits * BITC) @(negedge clk);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (((exp_q.size() != 0) || mon_busy) && (k < 40 * BITC)) begin
      @(negedge clk);
      k++;
    end
    check("drain_pending", exp_q.size(), 0);
    gap(3);
  endtask

  // UART transmit monitor: decodes frames and pops the scoreboard
  initial begin : tx_monitor
    logic [7:0] b;
    logic       sb;
    logic       tx_prev;
    logic       aborted;
    tx_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst && tx_prev && !cac_uart_tx) begin
        mon_busy    = 1'b1;
        mon_start_t = $time;
        aborted     = 1'b0;
        b           = 8'h00;
        repeat (BITC / 2) begin
          @(negedge clk);
          if (!rst) aborted = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
          repeat (BITC) begin
            @(negedge clk);
            if (!rst) aborted = 1'b1;
          end
          b = {b[6:0], cac_uart_tx};
        end
        repeat (BITC) begin
          @(negedge clk);
          if (!rst) aborted = 1'b1;
        end
        sb = cac_uart_tx;
        if (!aborted) begin
          check("tx_expected", (exp_q.size() != 0), 1);
          if (exp_q.size() != 0) check("tx_byte", b, exp_q.pop_front());
          check("tx_stop_bit", sb, 1);
        end
        mon_busy = 1'b0;
      end
      tx_prev = cac_uart_tx;
    end
  end

  initial begin : stimulus
    int trans;
    int k;
    logic prev;
    rst = 1'b0;
    rx  = 1'b1;
    model_reset();
    repeat (100) @(negedge clk);
    check("reset_tx_high", cac_uart_tx, 1);
    rst = 1'b1;

    // Quiet line after reset
    trans = 0;
    prev  = cac_uart_tx;
    repeat (1000) begin
      @(negedge clk);
      if (cac_uart_tx !== prev) trans++;
      prev = cac_uart_tx;
    end
    check("idle_transitions", trans, 0);
    check("idle_tx_high", cac_uart_tx, 1);

    // Back-to-back frames: reg0 = 0x00, reg1 = 0x01
    send_cmd(8'h10);
    send_cmd(8'h01);
    send_cmd(8'h11);
    send_cmd(8'h11);
    send_cmd(8'h30);
    wait_drain();
    send_cmd(8'h31);
    wait_drain();

    // Low then high nibble write, read back 0xAC
    send_cmd(8'h05); gap(2);
    send_cmd(8'h1C); gap(2);
    send_cmd(8'h2A); gap(2);
    send_cmd(8'h35);
    wait_drain();

    // Invalid opcode alone on an idle transmitter; also response latency
    send_cmd(8'h47);
    check("resp_latency_ok",
          (mon_start_t > stop_t) && ((mon_start_t - stop_t) <= time'((BITC / 2 + 6) * 10)), 1);
    wait_drain();
    // sel must still be 5 and reg5 untouched
    send_cmd(8'h35); gap(1);
    send_cmd(8'h13); gap(1);
    send_cmd(8'h35); gap(1);
    send_cmd(8'hF0);
    wait_drain();

    // Framing error: discarded, only the following valid READ answers
    send_byte(8'h31, 1'b0);
    gap(2);
    send_cmd(8'h31);
    wait_drain();

    // Reset in the middle of a READ response (reg0 = 0x00, line low)
    send_cmd(8'h30);
    k = 0;
    while ((cac_uart_tx !== 1'b0) && (k < 20 * BITC)) begin
      @(negedge clk);
      k++;
    end
    repeat (3 * BITC) @(negedge clk);
    check("mid_resp_tx_low", cac_uart_tx, 0);
    rst = 1'b0;
    #1;
    check("async_reset_tx_high", cac_uart_tx, 1);
    exp_q.delete();
    model_reset();
    repeat (20) @(negedge clk);
    rst = 1'b1;
    gap(12);
    check("post_reset_tx_high", cac_uart_tx, 1);
    send_cmd(8'h35);
    wait_drain();
    send_cmd(8'h30);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
